// File: rtl/uart_ecc_pkg.sv
// Shared definitions for the SECDED(8,4) UART transmitter and its future receiver.
package uart_ecc_pkg;

    localparam int unsigned NIB_BITS  = 4;
    localparam int unsigned CODE_BITS = 8;
    localparam int unsigned BIT_IDX_W = 4;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_GAP
    } tx_state_e;

    // Clock cycles per bit period (integer division).
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

    // Largest of three values; sizes the bit-time counter.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Hamming(7,4) plus overall parity: {p8,d3,d2,d1,p4,d0,p2,p1}.
    function automatic logic [CODE_BITS-1:0] hamming84_encode(input logic [NIB_BITS-1:0] d);
        logic p1, p2, p4, p8;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        p8 = ^{d, p1, p2, p4};
        return {p8, d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

endpackage

// File: rtl/hamming84_enc.sv
// Combinational SECDED(8,4) nibble encoder.
module hamming84_enc
    import uart_ecc_pkg::*;
(
    input  logic [NIB_BITS-1:0]  nib_i,
    output logic [CODE_BITS-1:0] code_o
);

    assign code_o = hamming84_encode(nib_i);

endmodule

// File: rtl/hamming_uart_tx_stream.sv
// Word-wide SECDED(8,4) UART transmitter: one encoded frame per nibble, nibble 0 first.
module hamming_uart_tx_stream
    import uart_ecc_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned GAP_BITS  = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic [8*(DATA_W/4)-1:0]     in_err_mask,
    output logic                        tx,
    output logic                        busy,
    output logic                        byte_done,
    output logic                        word_done
);

    localparam int unsigned NIB   = DATA_W / 4;
    localparam int unsigned CPB   = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned CNT_W = $clog2(max3(CPB * STOP_BITS, CPB * GAP_BITS, 2));
    localparam int unsigned NIB_W = $clog2(NIB + 1);
    localparam int unsigned BIT_W = BIT_IDX_W;

    tx_state_e                state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [BIT_W-1:0]         bit_q;
    logic [NIB_W-1:0]         nib_q;
    logic [DATA_W-1:0]        data_q;
    logic [8*NIB-1:0]         mask_q;
    logic                     tx_q;
    logic                     ready_q;
    logic                     busy_q;
    logic                     byte_done_q;
    logic                     word_done_q;

    logic [NIB_BITS-1:0]      nib_data_c;
    logic [CODE_BITS-1:0]     nib_mask_c;
    logic [CODE_BITS-1:0]     enc_c;
    logic [CODE_BITS-1:0]     code_c;
    logic                     bit_end_c;
    logic                     last_nib_c;

    // Select the active nibble and its error mask from the registered word.
    always_comb begin
        nib_data_c = '0;
        nib_mask_c = '0;
        for (int unsigned k = 0; k < NIB; k++) begin
            if (nib_q == NIB_W'(k)) begin
                nib_data_c = data_q[4*k +: 4];
                nib_mask_c = mask_q[8*k +: 8];
            end
        end
    end

    hamming84_enc u_enc (
        .nib_i  (nib_data_c),
        .code_o (enc_c)
    );

    assign code_c     = enc_c ^ nib_mask_c;
    assign bit_end_c  = (cnt_q == CNT_W'(CPB - 1));
    assign last_nib_c = (nib_q == NIB_W'(NIB - 1));

    // Frame sequencer with registered line and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= TX_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            nib_q       <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            tx_q        <= 1'b1;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            byte_done_q <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            byte_done_q <= 1'b0;
            word_done_q <= 1'b0;
            case (state_q)
                TX_IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        mask_q  <= in_err_mask;
                        state_q <= TX_START;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        nib_q   <= '0;
                    end
                end
                TX_START: begin
                    if (bit_end_c) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= TX_DATA;
                        tx_q    <= code_c[0];
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (bit_end_c) begin
                        cnt_q <= '0;
                        if (bit_q == BIT_W'(7)) begin
                            bit_q   <= '0;
                            state_q <= TX_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                            tx_q  <= code_c[3'(bit_q[2:0] + 3'd1)];
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    // Raise the pulses one edge early so they occupy the final stop cycle.
                    if (bit_q == BIT_W'(STOP_BITS - 1) && cnt_q == CNT_W'(CPB - 2)) begin
                        byte_done_q <= 1'b1;
                        word_done_q <= last_nib_c;
                    end
                    if (bit_end_c) begin
                        cnt_q <= '0;
                        if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                            bit_q <= '0;
                            if (last_nib_c) begin
                                state_q <= TX_IDLE;
                                nib_q   <= '0;
                                ready_q <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                nib_q <= nib_q + NIB_W'(1);
                                if (GAP_BITS != 0) begin
                                    state_q <= TX_GAP;
                                end else begin
                                    state_q <= TX_START;
                                    tx_q    <= 1'b0;
                                end
                            end
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                TX_GAP: begin
                    if (bit_end_c) begin
                        cnt_q <= '0;
                        if (bit_q == BIT_W'(GAP_BITS - 1)) begin
                            bit_q   <= '0;
                            state_q <= TX_START;
                            tx_q    <= 1'b0;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= TX_IDLE;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = ready_q;
    assign busy      = busy_q;
    assign tx        = tx_q;
    assign byte_done = byte_done_q;
    assign word_done = word_done_q;

endmodule
